// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv
// Iterative multiply/divide unit that owns the architectural HI/LO registers
// of the MIPS core. MULT/MULTU use a shift-add multiplier and DIV/DIVU use a
// restoring divider. Both work on operand magnitudes for 32 iterations, and
// the sign correction is applied in one final commit cycle. Every operation
// takes 33 enabled cycles from acceptance to commit.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset (overrides clk_enable)
//   clk_enable  freezes all state when low
//   start       request an operation (sampled in IDLE only)
//   op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b        rs / rt operands, sampled when start is accepted
//   hi_we       MTHI strobe (aborts a running operation)
//   lo_we       MTLO strobe (aborts a running operation)
//   wdata       MTHI/MTLO write data
//   busy        operation in progress
//   done        one-cycle pulse after HI/LO were updated by an operation
//   hi, lo      architectural HI / LO
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;
    logic [5:0]  count;

    // Operation context captured at acceptance
    logic        is_div;
    logic        sa, sb;
    logic        div_zero;
    logic [31:0] a_orig;
    logic [31:0] operand;   // |a| for multiply (addend), |b| for divide (divisor)

    // Working registers: accumulator high / partial remainder, and
    // accumulator low / quotient shift register
    logic [31:0] work_hi;
    logic [31:0] work_lo;

    logic        accept, abort, commit;
    logic        sa_in, sb_in;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] fix_hi, fix_lo;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    assign busy = (state != IDLE);

    // Control decode and next state
    always_comb begin
        accept     = (state == IDLE) && start;
        abort      = (state != IDLE) && (hi_we || lo_we);
        commit     = (state == FIX) && !abort;
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                if (abort)               state_next = IDLE;
                else if (count == 6'd31) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand magnitudes; 0x80000000 negates to itself, read as 2^31 unsigned
    always_comb begin
        sa_in = !op[0] && a[31];
        sb_in = !op[0] && b[31];
        mag_a = cond_neg32(a, sa_in);
        mag_b = cond_neg32(b, sb_in);
    end

    // One iteration of either algorithm
    always_comb begin
        // Multiply: conditional add into a 33-bit sum, then 65-bit shift right
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : 33'd0);
        // Divide: shift {rem, quo} left, trial-subtract the divisor
        div_shift = {work_hi, work_lo[31]};
        div_ge    = (div_shift >= {1'b0, operand});
    end

    // Result after sign correction
    always_comb begin
        fix_hi = 32'd0;
        fix_lo = 32'd0;
        if (is_div) begin
            if (div_zero) begin
                fix_hi = a_orig;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_lo = cond_neg32(work_lo, sa ^ sb);
                fix_hi = cond_neg32(work_hi, sa);
            end
        end else begin
            {fix_hi, fix_lo} = cond_neg64({work_hi, work_lo}, sa ^ sb);
        end
    end

    // Control state, done pulse and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 6'd0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (clk_enable) begin
            state <= state_next;
            done  <= commit;
            if (accept)
                count <= 6'd0;
            else if (state == CALC)
                count <= count + 6'd1;
            // An MTHI/MTLO during FIX aborts, so commit and write never coincide
            if (commit) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    // Datapath working registers (no reset; always reloaded on accept)
    always_ff @(posedge clk) begin
        if (clk_enable) begin
            if (accept) begin
                is_div   <= op[1];
                sa       <= sa_in;
                sb       <= sb_in;
                div_zero <= op[1] && (b == 32'd0);
                a_orig   <= a;
                work_hi  <= 32'd0;
                if (op[1]) begin
                    work_lo <= mag_a;
                    operand <= mag_b;
                end else begin
                    work_lo <= mag_b;
                    operand <= mag_a;
                end
            end else if (state == CALC) begin
                if (is_div) begin
                    // A kept difference is below the divisor, so it fits 32 bits
                    work_hi <= div_ge ? (div_shift[31:0] - operand) : div_shift[31:0];
                    work_lo <= {work_lo[30:0], div_ge};
                end else begin
                    work_hi <= mul_sum[32:1];
                    work_lo <= {mul_sum[0], work_lo[31:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Testbench for mips_cpu_muldiv: directed operations with a queue of expected
// HI/LO results, checked when done pulses.
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mips_cpu_muldiv dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation for one enabled edge (E0); operands are scrambled afterwards
    task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                         input string tag);
        exp_t e;
        if (push) begin
            e.hi = ehi;
            e.lo = elo;
            sb_q.push_back(e);
        end
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        check({tag, " busy@E0"}, 64'(busy), 64'd1);
        check({tag, " done@E0"}, 64'(done), 64'd0);
    endtask

    // Wait for done, checking busy and HI/LO hold each cycle, then score the result
    task automatic await_done(input int n_start, input int exp_n, input string tag);
        int   n;
        exp_t e;
        n = n_start;
        while (done !== 1'b1 && n < 200) begin
            check({tag, " busy"}, 64'(busy), 64'd1);
            check({tag, " hold"}, {hi, lo}, {model_hi, model_lo});
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_n));
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " hi"}, 64'(hi), 64'(e.hi));
            check({tag, " lo"}, 64'(lo), 64'(e.lo));
            model_hi = e.hi;
            model_lo = e.lo;
        end else begin
            check({tag, " scoreboard"}, 64'(sb_q.size()), 64'd1);
        end
    endtask

    task automatic pulse_end(input string tag);
        tick();
        check({tag, " done width"}, 64'(done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic no_done_for(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check({tag, " no done/busy"}, 64'(seen), 64'd0);
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 2'b00;
        a = 32'd0; b = 32'd0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        tick();
        tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        reset = 1'b0;

        // MTHI/MTLO in IDLE
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        model_hi = 32'hA5A5_0001; model_lo = 32'hA5A5_0001;
        check("mt both", {hi, lo}, {model_hi, model_lo});
        hi_we = 1'b1; wdata = 32'h0000_1111;
        tick();
        hi_we = 1'b0;
        model_hi = 32'h0000_1111;
        check("mthi only", {hi, lo}, {model_hi, model_lo});

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
        await_done(0, 33, "multu max");
        pulse_end("multu max");

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7");
        await_done(0, 33, "mult -3*7");
        pulse_end("mult -3*7");

        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, "mult min*min");
        await_done(0, 33, "mult min*min");
        // Back-to-back: new start presented while done is high
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
        await_done(0, 33, "div -7/2");
        pulse_end("div -7/2");

        issue(2'b11, 32'd7, 32'd2, 1'b1, 32'd1, 32'd3, "divu 7/2");
        await_done(0, 33, "divu 7/2");
        pulse_end("divu 7/2");

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, "div min/-1");
        await_done(0, 33, "div min/-1");
        pulse_end("div min/-1");

        issue(2'b11, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, "divu 5/0");
        await_done(0, 33, "divu 5/0");
        pulse_end("divu 5/0");

        issue(2'b10, 32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFF, "div -9/0");
        await_done(0, 33, "div -9/0");
        pulse_end("div -9/0");

        issue(2'b11, 32'd1000, 32'd7, 1'b1, 32'd6, 32'd142, "divu 1000/7");
        await_done(0, 33, "divu 1000/7");
        pulse_end("divu 1000/7");

        // Start together with MTHI: write lands at E0, FIX overwrites later
        hi_we = 1'b1; wdata = 32'h0000_7777;
        model_hi = 32'h0000_7777;
        issue(2'b00, 32'd2, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF6, "mult wr+start");
        hi_we = 1'b0;
        check("mult wr+start hi@E0", {hi, lo}, {model_hi, model_lo});
        await_done(0, 33, "mult wr+start");
        pulse_end("mult wr+start");

        // clk_enable stall mid-CALC plus ignored start while busy
        issue(2'b01, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, "multu en");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("en pre busy", 64'(busy), 64'd1);
        end
        clk_enable = 1'b0;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("en frozen busy", 64'(busy), 64'd1);
            check("en frozen done", 64'(done), 64'd0);
            check("en frozen hold", {hi, lo}, {model_hi, model_lo});
        end
        clk_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en start ignored busy", 64'(busy), 64'd1);
        end
        start = 1'b0;
        await_done(18, 43, "multu en");
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done held disabled", 64'(done), 64'd1);
        end
        clk_enable = 1'b1;
        pulse_end("multu en");

        // MTHI abort at cycle 10
        issue(2'b11, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd0, "abort");
        for (int i = 0; i < 9; i++) tick();
        hi_we = 1'b1; wdata = 32'h0000_1234;
        tick();
        hi_we = 1'b0;
        model_hi = 32'h0000_1234;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi/lo", {hi, lo}, {model_hi, model_lo});
        no_done_for(40, "abort");

        // Reset at cycle 20
        issue(2'b11, 32'd50, 32'd3, 1'b0, 32'd0, 32'd0, "reset op");
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_hi = 32'd0; model_lo = 32'd0;
        check("reset op busy", 64'(busy), 64'd0);
        check("reset op done", 64'(done), 64'd0);
        check("reset op hi/lo", {hi, lo}, {model_hi, model_lo});
        no_done_for(40, "reset op");

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
